// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard unit: FSM state encoding, PC
// address-select codes and the load-use detection helper.
package hazard_pkg;

  typedef enum logic {
    NO_HAZ     = 1'b0,
    BR_RESOLVE = 1'b1
  } state_t;

  localparam logic [1:0] ADDR_PC4    = 2'b00;
  localparam logic [1:0] ADDR_JUMP   = 2'b01;
  localparam logic [1:0] ADDR_BRANCH = 2'b10;

  // r0 is hard-wired zero, so a load into it never creates a dependency.
  function automatic logic load_use(
    input logic       ex_memread,
    input logic [4:0] ex_rw,
    input logic [4:0] id_rs,
    input logic [4:0] id_rt,
    input logic       use_shamt,
    input logic       use_immed
  );
    return ex_memread && (ex_rw != 5'd0) &&
           ((!use_shamt && (id_rs == ex_rw)) || (!use_immed && (id_rt == ex_rw)));
  endfunction

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Saturating up-counter with synchronous clear, used for hazard statistics.
// Built only when HAZARD_PERF_CNT_EN is defined.
`ifdef HAZARD_PERF_CNT_EN
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear)
      count <= '0;
    else if (inc && (count != {WIDTH{1'b1}}))
      count <= count + 1'b1;
  end

endmodule
`endif

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use stalls, jump flush and branch resolution.
// Optional stall/flush statistics counters under HAZARD_PERF_CNT_EN.
//
// state      | meaning
// NO_HAZ     | normal flow; detect load-use, jump and branch in ID
// BR_RESOLVE | branch moved to EX, ID holds a flushed nop; redirect on outcome
module hazard_unit
  import hazard_pkg::*;
(
  input  logic       CLK,
  input  logic       Reset,
  input  logic [4:0] ID_Rs,
  input  logic [4:0] ID_Rt,
  input  logic       UseShamt,
  input  logic       UseImmed,
  input  logic [4:0] EX_Rw,
  input  logic       EX_MemRead,
  input  logic       ID_Jump,
  input  logic       ID_Branch,
  input  logic       EX_BranchTaken,
  output logic       PC_Write,
  output logic       IFID_Write,
  output logic       IFID_Flush,
  output logic       Bubble,
  output logic [1:0] AddrSel
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0] StallCount,
  output logic [15:0] FlushCount
`endif
);

  state_t state;
  state_t next_state;
  logic   lu;
  logic   lu_stall;

  assign lu = load_use(EX_MemRead, EX_Rw, ID_Rs, ID_Rt, UseShamt, UseImmed);

  always_ff @(posedge CLK) begin
    if (Reset)
      state <= NO_HAZ;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    PC_Write   = 1'b1;
    IFID_Write = 1'b1;
    IFID_Flush = 1'b0;
    Bubble     = 1'b0;
    AddrSel    = ADDR_PC4;
    lu_stall   = 1'b0;

    if (Reset) begin
      next_state = NO_HAZ;
      PC_Write   = 1'b0;
      IFID_Write = 1'b0;
      IFID_Flush = 1'b1;
      Bubble     = 1'b1;
    end else begin
      case (state)
        NO_HAZ: begin
          if (lu) begin
            PC_Write   = 1'b0;
            IFID_Write = 1'b0;
            Bubble     = 1'b1;
            lu_stall   = 1'b1;
          end else if (ID_Jump) begin
            AddrSel    = ADDR_JUMP;
            IFID_Flush = 1'b1;
          end else if (ID_Branch) begin
            // Hold PC until the branch outcome is known in EX.
            PC_Write   = 1'b0;
            IFID_Flush = 1'b1;
            next_state = BR_RESOLVE;
          end
        end
        BR_RESOLVE: begin
          next_state = NO_HAZ;
          if (EX_BranchTaken) begin
            AddrSel    = ADDR_BRANCH;
            IFID_Flush = 1'b1;
          end
        end
        default: next_state = NO_HAZ;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  sat_counter #(.WIDTH(16)) u_stall_cnt (
    .clk   (CLK),
    .clear (Reset),
    .inc   (lu_stall),
    .count (StallCount)
  );

  sat_counter #(.WIDTH(16)) u_flush_cnt (
    .clk   (CLK),
    .clear (Reset),
    .inc   (IFID_Flush && !Reset),
    .count (FlushCount)
  );
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit; the counter test runs when
// HAZARD_PERF_CNT_EN is defined.
module tb_hazard_unit;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [4:0] ID_Rs, ID_Rt, EX_Rw;
  logic       UseShamt, UseImmed, EX_MemRead;
  logic       ID_Jump, ID_Branch, EX_BranchTaken;
  logic       PC_Write, IFID_Write, IFID_Flush, Bubble;
  logic [1:0] AddrSel;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] StallCount, FlushCount;
`endif

  int total  = 0;
  int passed = 0;

  // {PC_Write, IFID_Write, IFID_Flush, Bubble, AddrSel}; x in an expected
  // value marks a field left open for that situation.
  logic [5:0] outs;
  assign outs = {PC_Write, IFID_Write, IFID_Flush, Bubble, AddrSel};

  localparam logic [5:0] O_RESET = 6'b001100;
  localparam logic [5:0] O_IDLE  = 6'b110000;
  localparam logic [5:0] O_STALL = 6'b000100;
  localparam logic [5:0] O_JUMP  = 6'b1x1001;
  localparam logic [5:0] O_BR0   = 6'b0x10xx;
  localparam logic [5:0] O_TAKEN = 6'b1x1x10;
  localparam logic [5:0] O_NTKN  = 6'b110x00;

  always #5 CLK = ~CLK;

  hazard_unit dut (
    .CLK            (CLK),
    .Reset          (Reset),
    .ID_Rs          (ID_Rs),
    .ID_Rt          (ID_Rt),
    .UseShamt       (UseShamt),
    .UseImmed       (UseImmed),
    .EX_Rw          (EX_Rw),
    .EX_MemRead     (EX_MemRead),
    .ID_Jump        (ID_Jump),
    .ID_Branch      (ID_Branch),
    .EX_BranchTaken (EX_BranchTaken),
    .PC_Write       (PC_Write),
    .IFID_Write     (IFID_Write),
    .IFID_Flush     (IFID_Flush),
    .Bubble         (Bubble),
    .AddrSel        (AddrSel)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .StallCount     (StallCount),
    .FlushCount     (FlushCount)
`endif
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    ID_Rs = 5'd1; ID_Rt = 5'd2; EX_Rw = 5'd3;
    UseShamt = 1'b0; UseImmed = 1'b0; EX_MemRead = 1'b0;
    ID_Jump = 1'b0; ID_Branch = 1'b0; EX_BranchTaken = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    clear_inputs();
    step();
    total++;
    if ($isunknown(outs) || !(outs ==? O_RESET))
      $display("FAIL reset_outputs: got %b want %b", outs, O_RESET);
    else passed++;
    // Events on the inputs must not change the reset outputs.
    ID_Branch = 1'b1; ID_Jump = 1'b1;
    #1;
    total++;
    if ($isunknown(outs) || !(outs ==? O_RESET))
      $display("FAIL reset_overrides_inputs: got %b want %b", outs, O_RESET);
    else passed++;
    step();
    Reset = 1'b0;
    clear_inputs();
    #1;
    total++;
    if ($isunknown(outs) || !(outs ==? O_IDLE))
      $display("FAIL idle_after_reset: got %b want %b", outs, O_IDLE);
    else passed++;
  endtask

  task automatic test_load_use();
    EX_MemRead = 1'b1; EX_Rw = 5'd5; ID_Rs = 5'd5; UseShamt = 1'b0;
    #1;
    total++;
    if ($isunknown(outs) || !(outs ==? O_STALL))
      $display("FAIL lu_rs_stall: got %b want %b", outs, O_STALL);
    else passed++;
    step();
    EX_MemRead = 1'b0;
    #1;
    total++;
    if ($isunknown(outs) || !(outs ==? O_IDLE))
      $display("FAIL lu_release: got %b want %b", outs, O_IDLE);
    else passed++;
    step();
    EX_MemRead = 1'b1; EX_Rw = 5'd9; ID_Rs = 5'd1; ID_Rt = 5'd9; UseImmed = 1'b0;
    #1;
    total++;
    if ($isunknown(outs) || !(outs ==? O_STALL))
      $display("FAIL lu_rt_stall: got %b want %b", outs, O_STALL);
    else passed++;
    EX_Rw = 5'd5; ID_Rs = 5'd5; ID_Rt = 5'd2; UseShamt = 1'b1;
    #1;
    total++;
    if ($isunknown(outs) || !(outs ==? O_IDLE))
      $display("FAIL lu_shamt_masks_rs: got %b want %b", outs, O_IDLE);
    else passed++;
    step();
    clear_inputs();
  endtask

  task automatic test_no_stall();
    EX_MemRead = 1'b1; EX_Rw = 5'd0; ID_Rs = 5'd0; ID_Rt = 5'd0;
    #1;
    total++;
    if ($isunknown(outs) || !(outs ==? O_IDLE))
      $display("FAIL r0_no_stall: got %b want %b", outs, O_IDLE);
    else passed++;
    step();
    EX_Rw = 5'd7; ID_Rt = 5'd7; ID_Rs = 5'd4; UseImmed = 1'b1;
    #1;
    total++;
    if ($isunknown(outs) || !(outs ==? O_IDLE))
      $display("FAIL immed_masks_rt: got %b want %b", outs, O_IDLE);
    else passed++;
    step();
    clear_inputs();
  endtask

  task automatic test_branch();
    ID_Branch = 1'b1;
    #1;
    total++;
    if ($isunknown(outs) || !(outs ==? O_BR0))
      $display("FAIL br_cycle0: got %b want %b", outs, O_BR0);
    else passed++;
    step();
    ID_Branch = 1'b0; EX_BranchTaken = 1'b1;
    #1;
    total++;
    if ($isunknown(outs) || !(outs ==? O_TAKEN))
      $display("FAIL br_taken_cycle1: got %b want %b", outs, O_TAKEN);
    else passed++;
    step();
    // Back in NO_HAZ: a new branch is accepted (BR_RESOLVE would redirect).
    EX_BranchTaken = 1'b0; ID_Branch = 1'b1;
    #1;
    total++;
    if ($isunknown(outs) || !(outs ==? O_BR0))
      $display("FAIL br_back_to_nohaz: got %b want %b", outs, O_BR0);
    else passed++;
    step();
    ID_Branch = 1'b0;
    #1;
    total++;
    if ($isunknown(outs) || !(outs ==? O_NTKN))
      $display("FAIL br_not_taken: got %b want %b", outs, O_NTKN);
    else passed++;
    step();
    #1;
    total++;
    if ($isunknown(outs) || !(outs ==? O_IDLE))
      $display("FAIL br_after_not_taken: got %b want %b", outs, O_IDLE);
    else passed++;
  endtask

  task automatic test_br_ignores();
    ID_Branch = 1'b1;
    step();
    ID_Jump = 1'b1;
    EX_MemRead = 1'b1; EX_Rw = 5'd6; ID_Rs = 5'd6;
    #1;
    total++;
    if ($isunknown(outs) || !(outs ==? O_NTKN))
      $display("FAIL br_ignores_id: got %b want %b", outs, O_NTKN);
    else passed++;
    step();
    clear_inputs();
  endtask

  task automatic test_jump_lu();
    ID_Jump = 1'b1;
    EX_MemRead = 1'b1; EX_Rw = 5'd8; ID_Rs = 5'd8;
    #1;
    total++;
    if ($isunknown(outs) || !(outs ==? O_STALL))
      $display("FAIL jump_lu_stall: got %b want %b", outs, O_STALL);
    else passed++;
    step();
    EX_MemRead = 1'b0;
    #1;
    total++;
    if ($isunknown(outs) || !(outs ==? O_JUMP))
      $display("FAIL jump_after_stall: got %b want %b", outs, O_JUMP);
    else passed++;
    step();
    clear_inputs();
  endtask

  task automatic test_jump_and_branch();
    ID_Jump = 1'b1; ID_Branch = 1'b1;
    #1;
    total++;
    if ($isunknown(outs) || !(outs ==? O_JUMP))
      $display("FAIL jump_branch_both: got %b want %b", outs, O_JUMP);
    else passed++;
    step();
    ID_Jump = 1'b0;
    #1;
    total++;
    if ($isunknown(outs) || !(outs ==? O_BR0))
      $display("FAIL both_stays_nohaz: got %b want %b", outs, O_BR0);
    else passed++;
    step();
    clear_inputs();
    step();
  endtask

  task automatic test_reset_in_br();
    ID_Branch = 1'b1;
    step();
    ID_Branch = 1'b0; EX_BranchTaken = 1'b1; Reset = 1'b1;
    #1;
    total++;
    if ($isunknown(outs) || !(outs ==? O_RESET))
      $display("FAIL reset_in_br_outputs: got %b want %b", outs, O_RESET);
    else passed++;
    step();
    Reset = 1'b0; EX_BranchTaken = 1'b0; ID_Branch = 1'b1;
    #1;
    total++;
    if ($isunknown(outs) || !(outs ==? O_BR0))
      $display("FAIL reset_in_br_state: got %b want %b", outs, O_BR0);
    else passed++;
    step();
    clear_inputs();
    step();
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf_cnt();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    #1;
    total++;
    if (StallCount !== 16'd0 || FlushCount !== 16'd0)
      $display("FAIL cnt_clear: got %h/%h want 0000/0000", StallCount, FlushCount);
    else passed++;
    ID_Jump = 1'b1;
    repeat (3) step();
    ID_Jump = 1'b0;
    EX_MemRead = 1'b1; EX_Rw = 5'd5; ID_Rs = 5'd5;
    repeat (2) step();
    total++;
    if (FlushCount !== 16'd3 || StallCount !== 16'd2)
      $display("FAIL cnt_small: got %h/%h want 0003/0002", FlushCount, StallCount);
    else passed++;
    repeat (70000) step();
    total++;
    if (StallCount !== 16'hFFFF)
      $display("FAIL stall_saturate: got %h want ffff", StallCount);
    else passed++;
    repeat (5) step();
    total++;
    if (StallCount !== 16'hFFFF)
      $display("FAIL stall_hold: got %h want ffff", StallCount);
    else passed++;
    clear_inputs();
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_no_stall();
    test_branch();
    test_br_ignores();
    test_jump_lu();
    test_jump_and_branch();
    test_reset_in_br();
`ifdef HAZARD_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have port CLK, input, 1 bit, the single pipeline clock; all state updates on its rising edge.
REQ-002 SHALL have port Reset, input, 1 bit, synchronous active-high reset.
REQ-003 SHALL have ports ID_Rs and ID_Rt, inputs, 5 bits each, the source register fields of the instruction in ID.
REQ-004 SHALL have ports UseShamt and UseImmed, inputs, 1 bit each; when set, Rs or Rt respectively is not read by the ID instruction.
REQ-005 SHALL have ports EX_Rw, input, 5 bits, and EX_MemRead, input, 1 bit, the destination and load flag of the instruction in EX.
REQ-006 SHALL have ports ID_Jump and ID_Branch, inputs, 1 bit each, the jump and branch decode of the instruction in ID.
REQ-007 SHALL have port EX_BranchTaken, input, 1 bit, the branch outcome computed by the EX ALU.
REQ-008 SHALL have outputs PC_Write, IFID_Write, IFID_Flush and Bubble, 1 bit each; Bubble zeroes the ID/EX control fields.
REQ-009 SHALL have output AddrSel, 2 bits: 00 selects PC+4, 01 the jump target, 10 the branch target, 11 is reserved.

Function
REQ-010 SHALL implement the FSM states NO_HAZ and BR_RESOLVE, registered on CLK.
REQ-011 SHALL assert load-use hazard LU = EX_MemRead & EX_Rw!=0 & ((!UseShamt & ID_Rs==EX_Rw) | (!UseImmed & ID_Rt==EX_Rw)).
REQ-012 In NO_HAZ with LU=1, SHALL drive PC_Write=0, IFID_Write=0, Bubble=1, IFID_Flush=0, AddrSel=00, and stay in NO_HAZ.
REQ-013 LU SHALL take priority over ID_Jump and ID_Branch; the jump or branch is acted on in the first cycle LU=0.
REQ-014 In NO_HAZ with LU=0 and ID_Jump=1, SHALL drive PC_Write=1, AddrSel=01, IFID_Flush=1, Bubble=0, and stay in NO_HAZ.
REQ-015 In NO_HAZ with LU=0, ID_Jump=0 and ID_Branch=1, SHALL drive PC_Write=0, IFID_Flush=1, Bubble=0, and go to BR_RESOLVE.
REQ-016 In BR_RESOLVE with EX_BranchTaken=1, SHALL drive PC_Write=1, AddrSel=10, IFID_Flush=1, and go to NO_HAZ.
REQ-017 In BR_RESOLVE with EX_BranchTaken=0, SHALL drive PC_Write=1, AddrSel=00, IFID_Write=1, IFID_Flush=0, and go to NO_HAZ.
REQ-018 In BR_RESOLVE, SHALL ignore LU, ID_Jump and ID_Branch, because ID holds a flushed nop.
REQ-019 In NO_HAZ with no event, SHALL drive PC_Write=1, IFID_Write=1, IFID_Flush=0, Bubble=0, AddrSel=00.
REQ-020 ID_Jump and ID_Branch both high SHALL be treated as a jump.
REQ-021 All outputs SHALL be combinational from state and inputs, with zero-cycle latency; flush penalty SHALL be 1 cycle for a jump, 1 for a not-taken branch and 2 for a taken branch.

Reset
REQ-022 Reset=1 at a rising CLK edge SHALL force state to NO_HAZ, overriding any transition, including mid-BR_RESOLVE.
REQ-023 While Reset=1, outputs SHALL be PC_Write=0, IFID_Write=0, IFID_Flush=1, Bubble=1, AddrSel=00.

Configuration
REQ-024 With macro HAZARD_PERF_CNT_EN defined, SHALL add outputs StallCount and FlushCount, 16 bits each.
REQ-025 StallCount SHALL increment on each cycle with Bubble=1 from LU; FlushCount SHALL increment on each cycle with IFID_Flush=1 outside reset.
REQ-026 Both counters SHALL saturate at 16'hFFFF and clear on Reset.
REQ-027 Without HAZARD_PERF_CNT_EN, those ports and registers SHALL not exist, and all other behaviour SHALL be identical.

Structure
REQ-028 The state encoding and AddrSel constants (ADDR_PC4, ADDR_JUMP, ADDR_BRANCH) SHALL reside in shared package hazard_pkg.
REQ-029 Each counter SHALL be an instance of sub-module sat_counter (parameter WIDTH=16, inputs inc and clear), instantiated only under HAZARD_PERF_CNT_EN.

Verification
REQ-030 Stimulus: EX_MemRead=1, EX_Rw=5, ID_Rs=5, UseShamt=0. Required: exactly one cycle of PC_Write=0, IFID_Write=0, Bubble=1; next cycle with EX_MemRead=0, normal outputs.
REQ-031 Stimulus: EX_MemRead=1, EX_Rw=0, ID_Rs=0. Required: no stall. Stimulus: ID_Rt=EX_Rw=7 with UseImmed=1. Required: no stall.
REQ-032 Stimulus: ID_Branch=1, then EX_BranchTaken=1 next cycle. Required: cycle 0 PC_Write=0, IFID_Flush=1; cycle 1 AddrSel=10, IFID_Flush=1; cycle 2 state NO_HAZ.
REQ-033 Stimulus: ID_Branch=1, then EX_BranchTaken=0. Required: cycle 1 AddrSel=00, IFID_Write=1, IFID_Flush=0.
REQ-034 Stimulus: ID_Jump=1 with LU=1. Required: stall first, then AddrSel=01, IFID_Flush=1 next cycle. Stimulus: Reset asserted in BR_RESOLVE. Required: state NO_HAZ after the edge.
REQ-035 Stimulus (HAZARD_PERF_CNT_EN defined): 70000 forced stall cycles. Required: StallCount=16'hFFFF, and it holds at that value.
